// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit bus CPU: control-bit indices, opcodes and the
// sequencer state encoding.
package cpu_pkg;

    localparam int unsigned CTRL_W = 16;

    localparam int unsigned AI  = 0;
    localparam int unsigned AO  = 1;
    localparam int unsigned BI  = 2;
    localparam int unsigned BO  = 3;
    localparam int unsigned II  = 4;
    localparam int unsigned IO  = 5;
    localparam int unsigned IIO = 6;
    localparam int unsigned OI  = 7;
    localparam int unsigned OO  = 8;
    localparam int unsigned MI  = 9;
    localparam int unsigned MO  = 10;
    localparam int unsigned CE  = 11;
    localparam int unsigned CO  = 12;
    localparam int unsigned J   = 13;
    localparam int unsigned SU  = 14;
    localparam int unsigned EO  = 15;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JC  = 4'b0101;
    localparam logic [3:0] OP_JZ  = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StT0   = 3'd1,
        StT1   = 3'd2,
        StT2   = 3'd3,
        StT3   = 3'd4,
        StHalt = 3'd7
    } state_t;

    function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
        logic [CTRL_W-1:0] one;
        one = {{(CTRL_W-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (state, opcode, flags) -> control word plus
// end-of-instruction and illegal-opcode indications.
module microcode_rom
    import cpu_pkg::*;
(
    input  state_t             state,
    input  logic [3:0]         opcode,
    input  logic               carry,
    input  logic               zero,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               last,
    output logic               illegal
);

    always_comb begin
        ctrl    = '0;
        last    = 1'b0;
        illegal = 1'b0;
        unique case (state)
            StT0: ctrl = cbit(CO) | cbit(MI);
            StT1: ctrl = cbit(MO) | cbit(II) | cbit(CE);
            StT2: begin
                last = 1'b1;
                case (opcode)
                    OP_NOP: ctrl = '0;
                    OP_LDA: ctrl = cbit(IO) | cbit(IIO) | cbit(AI);
                    OP_ADD, OP_SUB: begin
                        ctrl = cbit(IO) | cbit(IIO) | cbit(BI);
                        last = 1'b0;
                    end
                    OP_JMP: ctrl = cbit(IO) | cbit(IIO) | cbit(J);
                    OP_JC:  ctrl = carry ? (cbit(IO) | cbit(IIO) | cbit(J)) : '0;
                    OP_JZ:  ctrl = zero ? (cbit(IO) | cbit(IIO) | cbit(J)) : '0;
                    OP_OUT: ctrl = cbit(AO) | cbit(OI);
                    // HLT ends by entering HALT, not by retiring.
                    OP_HLT: last = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            StT3: begin
                last = 1'b1;
                if (opcode == OP_SUB) begin
                    ctrl = cbit(EO) | cbit(AI) | cbit(SU);
                end else begin
                    ctrl = cbit(EO) | cbit(AI);
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer: holds the state register and run/step/halt transitions;
// the control word itself comes from the microcode ROM.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_step,
    input  logic [3:0]         i_opcode,
    input  logic               i_carry,
    input  logic               i_zero,
    output logic [CTRL_W-1:0]  o_ctrl,
    output logic [2:0]         o_state,
    output logic               o_retire,
    output logic               o_halted,
    output logic               o_illegal
);

    state_t state_q;
    logic   last;

    microcode_rom u_rom (
        .state   (state_q),
        .opcode  (i_opcode),
        .carry   (i_carry),
        .zero    (i_zero),
        .ctrl    (o_ctrl),
        .last    (last),
        .illegal (o_illegal)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (i_run || i_step) state_q <= StT0;
                StT0:   state_q <= StT1;
                StT1:   state_q <= StT2;
                StT2: begin
                    if (i_opcode == OP_HLT) begin
                        state_q <= StHalt;
                    end else if (last) begin
                        state_q <= i_run ? StT0 : StIdle;
                    end else begin
                        state_q <= StT3;
                    end
                end
                StT3:   state_q <= i_run ? StT0 : StIdle;
                StHalt: state_q <= StHalt;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_state  = state_q;
    assign o_retire = last;
    assign o_halted = (state_q == StHalt);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expectations are queued as
// stimulus is driven and popped against the DUT outputs mid-cycle.
module tb_control_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_run;
    logic        i_step;
    logic [3:0]  i_opcode;
    logic        i_carry;
    logic        i_zero;
    logic [15:0] o_ctrl;
    logic [2:0]  o_state;
    logic        o_retire;
    logic        o_halted;
    logic        o_illegal;

    typedef struct {
        string       tag;
        logic [15:0] ctrl;
        logic [2:0]  st;
        logic        ret;
        logic        hlt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    control_sequencer dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_run     (i_run),
        .i_step    (i_step),
        .i_opcode  (i_opcode),
        .i_carry   (i_carry),
        .i_zero    (i_zero),
        .o_ctrl    (o_ctrl),
        .o_state   (o_state),
        .o_retire  (o_retire),
        .o_halted  (o_halted),
        .o_illegal (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_now(input string tag, input logic [15:0] c, input logic [2:0] s,
                             input logic r, input logic h, input logic il);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.st = s; e.ret = r; e.hlt = h; e.ill = il;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        tests++;
        assert ({o_ctrl, o_state, o_retire, o_halted, o_illegal} ===
                {e.ctrl, e.st, e.ret, e.hlt, e.ill})
        else begin
            fails++;
            $error("FAIL %s: got ctrl=%h st=%0d ret=%b hlt=%b ill=%b, want ctrl=%h st=%0d ret=%b hlt=%b ill=%b",
                   e.tag, o_ctrl, o_state, o_retire, o_halted, o_illegal,
                   e.ctrl, e.st, e.ret, e.hlt, e.ill);
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] c, input logic [2:0] s,
                       input logic r, input logic h, input logic il);
        check_now(tag, c, s, r, h, il);
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b0; i_run = 1'b0; i_step = 1'b0;
        i_opcode = 4'h0; i_carry = 1'b0; i_zero = 1'b0;
        @(negedge i_clk);
        cyc("reset", 16'h0000, 3'd0, 0, 0, 0);
        i_rst = 1'b1;
        cyc("idle_hold", 16'h0000, 3'd0, 0, 0, 0);

        // Free-run program: LDA, ADD, OUT, HLT
        i_run = 1'b1; i_opcode = 4'b0001;
        cyc("go", 16'h0000, 3'd0, 0, 0, 0);
        cyc("lda_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("lda_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("lda_t2", 16'h0061, 3'd3, 1, 0, 0);
        i_opcode = 4'b0010;
        cyc("add_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("add_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("add_t2", 16'h0064, 3'd3, 0, 0, 0);
        cyc("add_t3", 16'h8001, 3'd4, 1, 0, 0);
        i_opcode = 4'b1110;
        cyc("out_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("out_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("out_t2", 16'h0082, 3'd3, 1, 0, 0);
        i_opcode = 4'b1111;
        cyc("hlt_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("hlt_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("hlt_t2", 16'h0000, 3'd3, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            i_step = i[0];
            cyc("halted", 16'h0000, 3'd7, 0, 1, 0);
        end
        i_step = 1'b0;

        // Async reset in T3 of ADD
        i_rst = 1'b0;
        cyc("rst_halt", 16'h0000, 3'd0, 0, 0, 0);
        i_rst = 1'b1; i_opcode = 4'b0010;
        cyc("go2", 16'h0000, 3'd0, 0, 0, 0);
        cyc("add2_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("add2_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("add2_t2", 16'h0064, 3'd3, 0, 0, 0);
        check_now("add2_t3", 16'h8001, 3'd4, 1, 0, 0);
        #1 i_rst = 1'b0;
        check_now("rst_mid_t3", 16'h0000, 3'd0, 0, 0, 0);
        @(negedge i_clk);
        i_run = 1'b0; i_rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc("quiet_after_rst", 16'h0000, 3'd0, 0, 0, 0);

        // Single step JC, carry clear; second pulse during T0 ignored
        i_opcode = 4'b0101; i_carry = 1'b0; i_step = 1'b1;
        cyc("step_jc0", 16'h0000, 3'd0, 0, 0, 0);
        cyc("jc0_t0", 16'h1200, 3'd1, 0, 0, 0);
        i_step = 1'b0;
        cyc("jc0_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("jc0_t2", 16'h0000, 3'd3, 1, 0, 0);
        cyc("jc0_idle", 16'h0000, 3'd0, 0, 0, 0);
        cyc("jc0_idle2", 16'h0000, 3'd0, 0, 0, 0);

        // Single step JC, carry set
        i_carry = 1'b1; i_step = 1'b1;
        cyc("step_jc1", 16'h0000, 3'd0, 0, 0, 0);
        i_step = 1'b0;
        cyc("jc1_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("jc1_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("jc1_t2", 16'h2060, 3'd3, 1, 0, 0);
        cyc("jc1_idle", 16'h0000, 3'd0, 0, 0, 0);

        // Single step JZ with zero set, carry clear
        i_opcode = 4'b0110; i_carry = 1'b0; i_zero = 1'b1; i_step = 1'b1;
        cyc("step_jz", 16'h0000, 3'd0, 0, 0, 0);
        i_step = 1'b0;
        cyc("jz_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("jz_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("jz_t2", 16'h2060, 3'd3, 1, 0, 0);
        cyc("jz_idle", 16'h0000, 3'd0, 0, 0, 0);

        // Illegal opcode while running, then SUB with run dropped in T1
        i_opcode = 4'b1010; i_zero = 1'b0; i_run = 1'b1;
        cyc("go_ill", 16'h0000, 3'd0, 0, 0, 0);
        cyc("ill_t0", 16'h1200, 3'd1, 0, 0, 0);
        cyc("ill_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("ill_t2", 16'h0000, 3'd3, 1, 0, 1);
        i_opcode = 4'b0011;
        cyc("sub_t0", 16'h1200, 3'd1, 0, 0, 0);
        i_run = 1'b0;
        cyc("sub_t1", 16'h0C10, 3'd2, 0, 0, 0);
        cyc("sub_t2", 16'h0064, 3'd3, 0, 0, 0);
        cyc("sub_t3", 16'h C001, 3'd4, 1, 0, 0);
        cyc("sub_idle", 16'h0000, 3'd0, 0, 0, 0);
        cyc("sub_idle2", 16'h0000, 3'd0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
